// File: rtl/class_arbiter_pkg.sv
// class_arbiter_pkg: shared state encodings, class-tag position and credit width
// for the two-class weighted arbiter.
package class_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } arb_state_t;

    localparam int CLASS_BIT = 9;
    localparam int CREDIT_W  = 4;

    typedef logic [CREDIT_W-1:0] credit_t;

    // Weights are 1..15; anything wider is truncated to the credit field.
    function automatic credit_t weight_to_credit(input int weight);
        return credit_t'(weight);
    endfunction

endpackage

// File: rtl/class_arbiter_credit.sv
// class_arb_credit: burst credit down-counter with load, decrement and
// terminal-count flags (zero now, and one left so the next pop ends the burst).
module class_arb_credit
    import class_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  credit_t load_val,
    input  logic    dec,
    output logic    zero,
    output logic    last
);

    credit_t credit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit <= '0;
        end else if (load) begin
            credit <= load_val;
        end else if (dec && !zero) begin
            credit <= credit - credit_t'(1);
        end
    end

    assign zero = (credit == '0);
    assign last = (credit == credit_t'(1));

endmodule

// File: rtl/class_arbiter.sv
// class_arbiter: weighted merge of two class FIFOs into one stream with a class-tag check.
// Per-class push counters exist only when CLASS_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | nothing granted; wait for a non-empty FIFO
// SERVE0 | class 0 owns the pop strobe until its credit runs out or it empties
// SERVE1 | class 1 owns the pop strobe until its credit runs out or it empties
module class_arbiter
    import class_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8,
    parameter int WEIGHT0   = 2,
    parameter int WEIGHT1   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty0,
    input  logic                 fifo_empty1,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic [DATA_SIZE-1:0] in1,
    output logic                 pop_0,
    output logic                 pop_1,
    input  logic                 almost_full_out,
    output logic [DATA_SIZE-1:0] out,
    output logic                 push_out,
    output logic                 Error,
    output logic [7:0]           count0,
    output logic [7:0]           count1
);

    localparam credit_t W0_CREDIT = weight_to_credit(WEIGHT0);
    localparam credit_t W1_CREDIT = weight_to_credit(WEIGHT1);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       credit_load;
    credit_t    credit_load_val;
    logic       credit_zero, credit_last;
    logic       cur_cls, cur_empty, oth_empty, burst_done;

    logic                 flight_vld, flight_cls;
    logic [DATA_SIZE-1:0] word;
    logic                 word_ok;

    class_arb_credit u_credit (
        .clk      (clk),
        .reset    (reset),
        .load     (credit_load),
        .load_val (credit_load_val),
        .dec      (pop_0 | pop_1),
        .zero     (credit_zero),
        .last     (credit_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        pop_0           = (state_q == ST_SERVE0) && !fifo_empty0 && !almost_full_out;
        pop_1           = (state_q == ST_SERVE1) && !fifo_empty1 && !almost_full_out;
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        credit_load     = 1'b0;
        credit_load_val = '0;
        cur_cls         = (state_q == ST_SERVE1);
        cur_empty       = cur_cls ? fifo_empty1 : fifo_empty0;
        oth_empty       = cur_cls ? fifo_empty0 : fifo_empty1;
        // The pop that spends the last credit ends the burst in the same cycle.
        burst_done      = cur_empty || credit_zero || ((pop_0 || pop_1) && credit_last);

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty0 && (fifo_empty1 || last_grant_q)) begin
                    state_d         = ST_SERVE0;
                    last_grant_d    = 1'b0;
                    credit_load     = 1'b1;
                    credit_load_val = W0_CREDIT;
                end else if (!fifo_empty1) begin
                    state_d         = ST_SERVE1;
                    last_grant_d    = 1'b1;
                    credit_load     = 1'b1;
                    credit_load_val = W1_CREDIT;
                end
            end
            ST_SERVE0, ST_SERVE1: begin
                if (burst_done) begin
                    if (!oth_empty) begin
                        state_d         = cur_cls ? ST_SERVE0 : ST_SERVE1;
                        last_grant_d    = !cur_cls;
                        credit_load     = 1'b1;
                        credit_load_val = cur_cls ? W0_CREDIT : W1_CREDIT;
                    end else if (!cur_empty) begin
                        credit_load     = 1'b1;
                        credit_load_val = cur_cls ? W1_CREDIT : W0_CREDIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO read data arrives the cycle after the pop; remember which class it belongs to.
    assign word    = flight_cls ? in1 : in0;
    assign word_ok = (word[CLASS_BIT] == flight_cls);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flight_vld <= 1'b0;
            flight_cls <= 1'b0;
            out        <= '0;
            push_out   <= 1'b0;
            Error      <= 1'b0;
        end else begin
            flight_vld <= pop_0 | pop_1;
            flight_cls <= pop_1;
            push_out   <= flight_vld & word_ok;
            if (flight_vld && word_ok) begin
                out <= {word[DATA_SIZE-1:MAIN_SIZE], word[MAIN_SIZE-1:0]};
            end
            if (flight_vld && !word_ok) begin
                Error <= 1'b1;
            end
        end
    end

`ifdef CLASS_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count0 <= '0;
            count1 <= '0;
        end else if (flight_vld && word_ok) begin
            if (!flight_cls && count0 != 8'hFF) begin
                count0 <= count0 + 8'd1;
            end
            if (flight_cls && count1 != 8'hFF) begin
                count1 <= count1 + 8'd1;
            end
        end
    end
`else
    assign count0 = '0;
    assign count1 = '0;
`endif

endmodule

// File: tb/tb_class_arbiter.sv
// tb_class_arbiter: directed bench with FIFO models, negedge monitor and per-scenario tasks.
module tb_class_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fifo_empty0, fifo_empty1;
    logic [9:0] in0 = '0;
    logic [9:0] in1 = '0;
    logic       pop_0, pop_1;
    logic       almost_full_out = 1'b0;
    logic [9:0] out;
    logic       push_out;
    logic       Error;
    logic [7:0] count0, count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    class_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty0     (fifo_empty0),
        .fifo_empty1     (fifo_empty1),
        .in0             (in0),
        .in1             (in1),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .almost_full_out (almost_full_out),
        .out             (out),
        .push_out        (push_out),
        .Error           (Error),
        .count0          (count0),
        .count1          (count1)
    );

    // FIFO models: write pointers owned by the stimulus, read pointers by the pop process.
    logic [9:0] mem0 [0:1023];
    logic [9:0] mem1 [0:1023];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;

    assign fifo_empty0 = (rp0 == wp0);
    assign fifo_empty1 = (rp1 == wp1);

    always @(posedge clk) begin
        if (pop_0) begin
            in0 <= mem0[rp0[9:0]];
            rp0 <= rp0 + 1;
        end
        if (pop_1) begin
            in1 <= mem1[rp1[9:0]];
            rp1 <= rp1 + 1;
        end
    end

    int         cyc = 0;
    int         viol = 0;
    int         pop_cyc[$];
    logic       pop_cls[$];
    int         push_cyc[$];
    logic [9:0] push_word[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pop_0) begin
            pop_cyc.push_back(cyc);
            pop_cls.push_back(1'b0);
            if (fifo_empty0) viol = viol + 1;
        end
        if (pop_1) begin
            pop_cyc.push_back(cyc);
            pop_cls.push_back(1'b1);
            if (fifo_empty1) viol = viol + 1;
        end
        if (pop_0 && pop_1) viol = viol + 1;
        if (push_out) begin
            push_cyc.push_back(cyc);
            push_word.push_back(out);
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [9:0] w);
        mem0[wp0[9:0]] = w;
        wp0 = wp0 + 1;
    endtask

    task automatic load1(input logic [9:0] w);
        mem1[wp1[9:0]] = w;
        wp1 = wp1 + 1;
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        reset = 1'b0;
        load0(10'h0FF); load0(10'h0EE);
        load1(10'h2DD); load1(10'h2CC);
        repeat (6) begin
            sample();
            obs = {pop_0, pop_1, push_out, Error, out, count0, count1};
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
    endtask

    task automatic test_basic_order();
        int p, q, n;
        logic [9:0] exp_w [4];
        exp_w[0] = 10'h0FF; exp_w[1] = 10'h0EE; exp_w[2] = 10'h2DD; exp_w[3] = 10'h2CC;
        p = push_cyc.size();
        q = pop_cyc.size();
        step();
        reset = 1'b1;
        sample();
        n_checks++;
        if (push_out !== 1'b0) begin
            n_fail++;
            $display("FAIL push_after_release: got %b expected 0", push_out);
        end
        for (n = 0; n < 40 && push_cyc.size() < p + 4; n++) sample();
        n_checks++;
        if (push_cyc.size() < p + 4) begin
            n_fail++;
            $display("FAIL basic_timeout: got %0d pushes expected 4", push_cyc.size() - p);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (push_word[p+i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: got %h expected %h", i, push_word[p+i], exp_w[i]);
                end
            end
            n_checks++;
            if (pop_cls[q] !== 1'b0 || push_cyc[p] - pop_cyc[q] != 2) begin
                n_fail++;
                $display("FAIL basic_latency: got class %b delay %0d expected class 0 delay 2",
                         pop_cls[q], push_cyc[p] - pop_cyc[q]);
            end
        end
        repeat (5) sample();
    endtask

    task automatic test_weights();
        int p, q, n;
        logic exp_cls;
        step();
        for (int i = 0; i < 20; i++) begin
            load0({2'b00, 8'(i)});
            load1({2'b10, 8'(i)});
        end
        p = push_cyc.size();
        q = pop_cyc.size();
        for (n = 0; n < 60 && push_cyc.size() < p + 40; n++) sample();
        n_checks++;
        if (push_cyc.size() < p + 40) begin
            n_fail++;
            $display("FAIL weights_timeout: got %0d pushes expected 40", push_cyc.size() - p);
        end else begin
            for (int i = 0; i < 9; i++) begin
                exp_cls = ((i % 3) == 2);
                n_checks++;
                if (pop_cls[q+i] !== exp_cls || pop_cyc[q+i] != pop_cyc[q] + i) begin
                    n_fail++;
                    $display("FAIL weights_pop%0d: got class %b cycle +%0d expected class %b cycle +%0d",
                             i, pop_cls[q+i], pop_cyc[q+i] - pop_cyc[q], exp_cls, i);
                end
                n_checks++;
                if (push_cyc[p+i] != pop_cyc[q+i] + 2 || push_word[p+i][9] !== exp_cls) begin
                    n_fail++;
                    $display("FAIL weights_push%0d: got tag %b delay %0d expected tag %b delay 2",
                             i, push_word[p+i][9], push_cyc[p+i] - pop_cyc[q+i], exp_cls);
                end
            end
        end
        repeat (4) sample();
    endtask

    task automatic test_backpressure();
        int p, q, n, c2;
        step();
        for (int i = 0; i < 6; i++) load0(10'h040 + 10'(i));
        p = push_cyc.size();
        q = pop_cyc.size();
        for (n = 0; n < 20 && pop_cyc.size() < q + 2; n++) sample();
        c2 = cyc;
        step();
        almost_full_out = 1'b1;
        sample();
        n_checks++;
        if (pop_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stop: got pop_0=%b expected 0", pop_0);
        end
        repeat (4) sample();
        n_checks++;
        if (pop_cyc.size() != q + 2) begin
            n_fail++;
            $display("FAIL bp_pops: got %0d pops expected 2", pop_cyc.size() - q);
        end
        n_checks++;
        if (push_cyc.size() != p + 2 || push_cyc[p] < c2 + 1) begin
            n_fail++;
            $display("FAIL bp_inflight: got %0d pushes expected 2 from cycle %0d", push_cyc.size() - p, c2 + 1);
        end
        step();
        almost_full_out = 1'b0;
        sample();
        n_checks++;
        if (pop_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: got pop_0=%b expected 1", pop_0);
        end
        for (n = 0; n < 20 && push_cyc.size() < p + 6; n++) sample();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (push_cyc.size() <= p + i || push_word[p+i] !== 10'h040 + 10'(i)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h expected %h", i,
                         (push_cyc.size() > p + i) ? push_word[p+i] : 10'h3FF, 10'h040 + 10'(i));
            end
        end
        repeat (4) sample();
    endtask

    task automatic test_class_error();
        int p, q, n;
        step();
        load0(10'h2AA);
        load0(10'h011);
        p = push_cyc.size();
        q = pop_cyc.size();
        for (n = 0; n < 20 && pop_cyc.size() <= q; n++) sample();
        sample();
        n_checks++;
        if (Error !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early: got %b expected 0", Error);
        end
        sample();
        n_checks++;
        if (Error !== 1'b1 || push_out !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: got Error=%b push=%b expected Error=1 push=0", Error, push_out);
        end
        step();
        load1(10'h233);
        load1(10'h244);
        repeat (10) sample();
        n_checks++;
        if (push_cyc.size() != p + 3 || push_word[p] !== 10'h011) begin
            n_fail++;
            $display("FAIL err_drop: got %0d pushes first %h expected 3 pushes first 011",
                     push_cyc.size() - p, (push_cyc.size() > p) ? push_word[p] : 10'h3FF);
        end
        n_checks++;
        if (Error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", Error);
        end
    endtask

    task automatic test_reset_mid();
        int n, p, q;
        logic [28:0] obs;
        logic seen;
        step();
        for (int i = 0; i < 6; i++) begin
            load0(10'h010 + 10'(i));
            load1(10'h220 + 10'(i));
        end
        seen = 1'b0;
        for (n = 0; n < 30 && !seen; n++) begin
            sample();
            seen = pop_1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_timeout: got no pop_1 expected one");
        end
        step();
        reset = 1'b0;
        repeat (3) begin
            sample();
            obs = {pop_0, pop_1, push_out, Error, out, count0, count1};
            n_checks++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL midrst_outputs: got %h expected 0", obs);
            end
        end
        p = push_cyc.size();
        q = pop_cyc.size();
        step();
        reset = 1'b1;
        sample();
        n_checks++;
        if (push_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release_push: got %b expected 0", push_out);
        end
        for (n = 0; n < 10 && pop_cyc.size() <= q; n++) sample();
        n_checks++;
        if (pop_cyc.size() <= q || pop_cls[q] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart: got class %b expected 0",
                     (pop_cyc.size() > q) ? pop_cls[q] : 1'bx);
        end
        for (n = 0; n < 60 && !(fifo_empty0 && fifo_empty1); n++) sample();
        repeat (5) sample();
        n_checks++;
        if (push_cyc.size() - p != pop_cyc.size() - q) begin
            n_fail++;
            $display("FAIL midrst_drain: got %0d pushes expected %0d",
                     push_cyc.size() - p, pop_cyc.size() - q);
        end
    endtask

    task automatic test_stats();
        int p, n;
        logic [7:0] exp_mid, exp_end;
`ifdef CLASS_ARB_STATS_EN
        exp_mid = 8'd5;
        exp_end = 8'hFF;
`else
        exp_mid = 8'd0;
        exp_end = 8'd0;
`endif
        step();
        reset = 1'b0;
        repeat (2) sample();
        step();
        reset = 1'b1;
        for (int i = 0; i < 300; i++) load0({2'b00, 8'(i)});
        p = push_cyc.size();
        for (n = 0; n < 1000 && push_cyc.size() < p + 300; n++) begin
            sample();
            if (push_cyc.size() == p + 5 && push_out === 1'b1) begin
                n_checks++;
                if (count0 !== exp_mid) begin
                    n_fail++;
                    $display("FAIL stats_mid: got %h expected %h", count0, exp_mid);
                end
            end
        end
        sample();
        n_checks++;
        if (push_cyc.size() != p + 300) begin
            n_fail++;
            $display("FAIL stats_pushes: got %0d expected 300", push_cyc.size() - p);
        end
        n_checks++;
        if (count0 !== exp_end || count1 !== 8'h00) begin
            n_fail++;
            $display("FAIL stats_counts: got %h/%h expected %h/00", count0, count1, exp_end);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL pop_invariants: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_weights();
        test_backpressure();
        test_class_error();
        test_reset_mid();
        test_stats();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
